// File: rtl/div_seq_restoring.sv
// Iterative unsigned radix-2 restoring divider: 2*DATA_LEN / DATA_LEN -> DATA_LEN quotient and remainder.
// Optional macro DIV_EARLY_TERM_EN: error operations (divide by zero / overflow) finish one cycle after accept.
module div_seq_restoring #(
    parameter int DATA_LEN = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2*DATA_LEN-1:0] dividend,
    input  logic [DATA_LEN-1:0]   divisor,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_LEN-1:0]   quotient,
    output logic [DATA_LEN-1:0]   remainder,
    output logic                  div_by_zero,
    output logic                  overflow
);

    localparam int                CNT_W    = $clog2(DATA_LEN) + 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_LEN - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t              state;
    logic [DATA_LEN:0]   rem;
    logic [DATA_LEN-1:0] q;
    logic [DATA_LEN-1:0] dsr;
    logic [CNT_W-1:0]    cnt;
    logic                dz;
    logic                ovf;

    logic                acc_dz;
    logic                acc_ovf;
    logic [DATA_LEN:0]   rem_sh;
    logic                rem_ge;
    logic [DATA_LEN:0]   rem_nx;
    logic [DATA_LEN-1:0] q_nx;
    logic                calc_last;

    // Error results saturate: quotient all ones, remainder zero.
    function automatic logic [DATA_LEN-1:0] sat_quotient(input logic [DATA_LEN-1:0] qv,
                                                         input logic              err);
        return err ? {DATA_LEN{1'b1}} : qv;
    endfunction

    function automatic logic [DATA_LEN-1:0] sat_remainder(input logic [DATA_LEN:0] rv,
                                                          input logic            err);
        return err ? {DATA_LEN{1'b0}} : rv[DATA_LEN-1:0];
    endfunction

    always_comb begin
        acc_dz  = (divisor == '0);
        acc_ovf = !acc_dz && (dividend[2*DATA_LEN-1:DATA_LEN] >= divisor);

        // A set rem MSB means the shifted value exceeds any divisor, so it always subtracts.
        rem_sh  = {rem[DATA_LEN-1:0], q[DATA_LEN-1]};
        rem_ge  = rem[DATA_LEN] || (rem_sh >= {1'b0, dsr});
        rem_nx  = rem_ge ? (rem_sh - {1'b0, dsr}) : rem_sh;
        q_nx    = {q[DATA_LEN-2:0], rem_ge};

`ifdef DIV_EARLY_TERM_EN
        calc_last = (cnt == CNT_LAST) || dz || ovf;
`else
        calc_last = (cnt == CNT_LAST);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            rem         <= '0;
            q           <= '0;
            dsr         <= '0;
            cnt         <= '0;
            dz          <= 1'b0;
            ovf         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        rem      <= {1'b0, dividend[2*DATA_LEN-1:DATA_LEN]};
                        q        <= dividend[DATA_LEN-1:0];
                        dsr      <= divisor;
                        cnt      <= '0;
                        dz       <= acc_dz;
                        ovf      <= acc_ovf;
                        in_ready <= 1'b0;
                        state    <= CALC;
                    end
                end

                CALC: begin
                    rem <= rem_nx;
                    q   <= q_nx;
                    cnt <= cnt + CNT_W'(1);
                    if (calc_last) begin
                        quotient    <= sat_quotient(q_nx, dz || ovf);
                        remainder   <= sat_remainder(rem_nx, dz || ovf);
                        div_by_zero <= dz;
                        overflow    <= ovf;
                        out_valid   <= 1'b1;
                        state       <= DONE;
                    end
                end

                DONE: begin
                    // Result is held until taken; in_ready rises only after, giving a one-cycle bubble.
                    if (out_ready) begin
                        out_valid   <= 1'b0;
                        quotient    <= '0;
                        remainder   <= '0;
                        div_by_zero <= 1'b0;
                        overflow    <= 1'b0;
                        in_ready    <= 1'b1;
                        state       <= IDLE;
                    end
                end

                default: begin
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq_restoring.sv
// Self-checking bench for div_seq_restoring with a scoreboard queue of expected results.
// Honors DIV_EARLY_TERM_EN for the expected latency of error operations.
module tb_div_seq_restoring;

    localparam int N = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [2*N-1:0] dividend = '0;
    logic [N-1:0]   divisor = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [N-1:0]   quotient;
    logic [N-1:0]   remainder;
    logic           div_by_zero;
    logic           overflow;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [N-1:0] q;
        logic [N-1:0] r;
        logic         dz;
        logic         ovf;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    div_seq_restoring #(.DATA_LEN(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .dividend   (dividend),
        .divisor    (divisor),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero),
        .overflow   (overflow)
    );

    function automatic exp_t model(input logic [2*N-1:0] a, input logic [N-1:0] b);
        exp_t e;
        e = '0;
        if (b == '0) begin
            e.q  = '1;
            e.dz = 1'b1;
        end else if (a[2*N-1:N] >= b) begin
            e.q   = '1;
            e.ovf = 1'b1;
        end else begin
            e.q = N'(a / {8'h00, b});
            e.r = N'(a % {8'h00, b});
        end
        return e;
    endfunction

    function automatic int exp_lat(input exp_t e);
`ifdef DIV_EARLY_TERM_EN
        return (e.dz || e.ovf) ? 1 : N;
`else
        if (e.dz || e.ovf) return N;
        return N;
`endif
    endfunction

    function automatic exp_t observed();
        exp_t g;
        g.q   = quotient;
        g.r   = remainder;
        g.dz  = div_by_zero;
        g.ovf = overflow;
        return g;
    endfunction

    // Entered and left at #1 after a rising edge; the edge inside is the accept edge.
    task automatic send(input logic [2*N-1:0] a, input logic [N-1:0] b, input exp_t e);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_wait_ready: in_ready=%0b, required 1 within 40 cycles", in_ready);
        end
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        sb.push_back(e);
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) break;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({in_ready, out_valid, quotient, remainder, div_by_zero, overflow} !== {1'b1, 1'b0, 16'h0000, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b q=%h r=%h dz=%b ovf=%b, required 1 0 00 00 0 0",
                     in_ready, out_valid, quotient, remainder, div_by_zero, overflow);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_normal();
        logic [2*N-1:0] dv[9];
        logic [N-1:0]   ds[9];
        exp_t           ex[9];
        exp_t           e;
        exp_t           g;
        int             lat;
        dv[0] = 16'h3039; ds[0] = 8'h65; ex[0] = '{8'h7A, 8'h17, 1'b0, 1'b0};
        dv[1] = 16'hFE01; ds[1] = 8'hFF; ex[1] = '{8'hFF, 8'h00, 1'b0, 1'b0};
        dv[2] = 16'h00FF; ds[2] = 8'h01; ex[2] = '{8'hFF, 8'h00, 1'b0, 1'b0};
        dv[3] = 16'h0000; ds[3] = 8'h07; ex[3] = '{8'h00, 8'h00, 1'b0, 1'b0};
        dv[4] = 16'h11FF; ds[4] = 8'h12; ex[4] = '{8'hFF, 8'h11, 1'b0, 1'b0};
        for (int i = 5; i < 9; i++) begin
            ds[i] = 8'($urandom_range(2, 255));
            dv[i] = {8'($urandom_range(0, 32'(ds[i]) - 1)), 8'($urandom)};
            ex[i] = model(dv[i], ds[i]);
        end
        for (int i = 0; i < 9; i++) begin
            send(dv[i], ds[i], ex[i]);
            wait_result(lat);
            e = sb.pop_front();
            g = observed();
            n_checks++;
            if (lat !== exp_lat(e)) begin
                n_fail++;
                $display("FAIL normal_latency[%0d]: %0d cycles, required %0d", i, lat, exp_lat(e));
            end
            n_checks++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL normal_result[%0d] %h/%h: q=%h r=%h dz=%b ovf=%b, required q=%h r=%h dz=%b ovf=%b",
                         i, dv[i], ds[i], g.q, g.r, g.dz, g.ovf, e.q, e.r, e.dz, e.ovf);
            end
            release_result();
            n_checks++;
            if ({in_ready, out_valid} !== 2'b10) begin
                n_fail++;
                $display("FAIL normal_return_idle[%0d]: in_ready=%b out_valid=%b, required 1 0", i, in_ready, out_valid);
            end
        end
    endtask

    task automatic test_errors();
        logic [2*N-1:0] dv[3];
        logic [N-1:0]   ds[3];
        exp_t           ex[3];
        exp_t           e;
        exp_t           g;
        int             lat;
        dv[0] = 16'h1234; ds[0] = 8'h00; ex[0] = '{8'hFF, 8'h00, 1'b1, 1'b0};
        dv[1] = 16'h1234; ds[1] = 8'h12; ex[1] = '{8'hFF, 8'h00, 1'b0, 1'b1};
        dv[2] = 16'hFFFF; ds[2] = 8'hFF; ex[2] = '{8'hFF, 8'h00, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            send(dv[i], ds[i], ex[i]);
            wait_result(lat);
            e = sb.pop_front();
            g = observed();
            n_checks++;
`ifdef DIV_EARLY_TERM_EN
            if (lat !== 1) begin
                n_fail++;
                $display("FAIL error_latency[%0d]: %0d cycles, required 1", i, lat);
            end
`else
            if (lat !== N) begin
                n_fail++;
                $display("FAIL error_latency[%0d]: %0d cycles, required %0d", i, lat, N);
            end
`endif
            n_checks++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL error_result[%0d] %h/%h: q=%h r=%h dz=%b ovf=%b, required q=%h r=%h dz=%b ovf=%b",
                         i, dv[i], ds[i], g.q, g.r, g.dz, g.ovf, e.q, e.r, e.dz, e.ovf);
            end
            release_result();
            n_checks++;
            if ({div_by_zero, overflow, out_valid} !== 3'b000) begin
                n_fail++;
                $display("FAIL error_flags_cleared[%0d]: dz=%b ovf=%b out_valid=%b, required 0 0 0",
                         i, div_by_zero, overflow, out_valid);
            end
        end
    endtask

    task automatic test_backpressure();
        exp_t e;
        exp_t g;
        int   lat;
        bit   busy_ready;
        send(16'h3039, 8'h65, '{8'h7A, 8'h17, 1'b0, 1'b0});
        // A competing request held during CALC and DONE must be ignored.
        in_valid   = 1'b1;
        dividend   = 16'h0100;
        divisor    = 8'h02;
        busy_ready = 1'b0;
        lat        = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) break;
            if (in_ready) busy_ready = 1'b1;
            @(posedge clk);
            #1;
            lat++;
        end
        e = sb.pop_front();
        n_checks++;
        if (busy_ready || lat !== N) begin
            n_fail++;
            $display("FAIL bp_calc: in_ready_seen=%b latency=%0d, required 0 and %0d", busy_ready, lat, N);
        end
        for (int c = 0; c < 5; c++) begin
            g = observed();
            n_checks++;
            if (g !== e || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: out_valid=%b in_ready=%b q=%h r=%h dz=%b ovf=%b, required 1 0 q=%h r=%h dz=0 ovf=0",
                         c, out_valid, in_ready, g.q, g.r, g.dz, g.ovf, e.q, e.r);
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        release_result();
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_ready_after_take: in_ready=%b, required 1", in_ready);
        end
        busy_ready = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (out_valid || !in_ready) busy_ready = 1'b1;
        end
        n_checks++;
        if (busy_ready) begin
            n_fail++;
            $display("FAIL bp_no_second_accept: activity=%b, required 0", busy_ready);
        end
    endtask

    task automatic test_back_to_back();
        logic [2*N-1:0] a;
        logic [N-1:0]   b;
        exp_t           e;
        exp_t           g;
        int             lat;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            b = (i == 2) ? 8'h00 : 8'($urandom_range(1, 255));
            a = (i == 4) ? {b, 8'h3C} : 16'($urandom);
            send(a, b, model(a, b));
            out_ready = 1'b1;
            wait_result(lat);
            e = sb.pop_front();
            g = observed();
            n_checks++;
            if (lat !== exp_lat(e) || g !== e) begin
                n_fail++;
                $display("FAIL b2b[%0d] %h/%h: lat=%0d q=%h r=%h dz=%b ovf=%b, required lat=%0d q=%h r=%h dz=%b ovf=%b",
                         i, a, b, lat, g.q, g.r, g.dz, g.ovf, exp_lat(e), e.q, e.r, e.dz, e.ovf);
            end
            @(posedge clk);
            #1;
            n_checks++;
            if ({in_ready, out_valid} !== 2'b10) begin
                n_fail++;
                $display("FAIL b2b_bubble[%0d]: in_ready=%b out_valid=%b, required 1 0", i, in_ready, out_valid);
            end
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        exp_t e;
        exp_t g;
        int   lat;
        send(16'h3039, 8'h65, '{8'h7A, 8'h17, 1'b0, 1'b0});
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({in_ready, out_valid, quotient, remainder, div_by_zero, overflow} !== {1'b1, 1'b0, 16'h0000, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_mid_calc: in_ready=%b out_valid=%b q=%h r=%h dz=%b ovf=%b, required 1 0 00 00 0 0",
                     in_ready, out_valid, quotient, remainder, div_by_zero, overflow);
        end
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(16'h3039, 8'h65, '{8'h7A, 8'h17, 1'b0, 1'b0});
        wait_result(lat);
        e = sb.pop_front();
        g = observed();
        n_checks++;
        if (lat !== N || g !== e) begin
            n_fail++;
            $display("FAIL reset_mid_fresh: lat=%0d q=%h r=%h, required lat=%0d q=%h r=%h", lat, g.q, g.r, N, e.q, e.r);
        end
        // Reset while a result is being held must also clear it at once.
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({in_ready, out_valid, quotient, remainder, div_by_zero, overflow} !== {1'b1, 1'b0, 16'h0000, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_in_done: in_ready=%b out_valid=%b q=%h r=%h dz=%b ovf=%b, required 1 0 00 00 0 0",
                     in_ready, out_valid, quotient, remainder, div_by_zero, overflow);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_normal();
        test_errors();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
